// File: rtl/regfile_pkg.sv
// Shared types, defaults and boot table for the multi-port register file.
// Optional debug ports are enabled with REGFILE_MP_DEBUG_PORT_EN.
package regfile_pkg;

    localparam int DEF_XLEN  = 32;
    localparam int DEF_NREGS = 32;
    localparam int DEF_AW    = $clog2(DEF_NREGS);

    typedef enum logic {
        INIT,
        RUN
    } rf_state_e;

    // Values loaded into the architectural registers after every reset or reinit.
    localparam logic [DEF_XLEN-1:0] RF_BOOT [DEF_NREGS] = '{
        1:       32'd24,
        2:       32'd2,
        5:       32'd5,
        10:      32'd56,
        31:      32'd3,
        default: 32'd0
    };

    function automatic logic [DEF_XLEN-1:0] rf_boot_word(input logic [31:0] idx);
        logic [DEF_XLEN-1:0] word;
        word = '0;
        if (idx < 32'(DEF_NREGS)) begin
            word = RF_BOOT[idx[DEF_AW-1:0]];
        end
        return word;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle between writeback/decode and the register file.
// Debug signals exist only when REGFILE_MP_DEBUG_PORT_EN is defined.
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int XLEN  = DEF_XLEN,
    parameter int NREGS = DEF_NREGS,
    parameter int NRD   = 2,
    parameter int NWR   = 2
);
    localparam int AW = $clog2(NREGS);

    logic                          i_reinit;
    logic                          o_ready;
    logic [NRD-1:0][AW-1:0]        i_rd_addr;
    logic [NRD-1:0][XLEN-1:0]      o_rd_data;
    logic [NWR-1:0]                i_we;
    logic [NWR-1:0][AW-1:0]        i_wr_addr;
    logic [NWR-1:0][XLEN-1:0]      i_wr_data;
    logic                          o_wr_conflict;
`ifdef REGFILE_MP_DEBUG_PORT_EN
    logic [NREGS-1:0][XLEN-1:0]    o_dbg_regs;
    logic [31:0]                   o_dbg_wr_count;

    modport master (
        output i_reinit, i_rd_addr, i_we, i_wr_addr, i_wr_data,
        input  o_ready, o_rd_data, o_wr_conflict, o_dbg_regs, o_dbg_wr_count
    );
    modport slave (
        input  i_reinit, i_rd_addr, i_we, i_wr_addr, i_wr_data,
        output o_ready, o_rd_data, o_wr_conflict, o_dbg_regs, o_dbg_wr_count
    );
`else
    modport master (
        output i_reinit, i_rd_addr, i_we, i_wr_addr, i_wr_data,
        input  o_ready, o_rd_data, o_wr_conflict
    );
    modport slave (
        input  i_reinit, i_rd_addr, i_we, i_wr_addr, i_wr_data,
        output o_ready, o_rd_data, o_wr_conflict
    );
`endif

endinterface

// File: rtl/rf_wr_arbiter.sv
// Per-register write winner selection, zero-register drop and conflict detection.
// The per-register result feeds both the array update and the read bypass.
module rf_wr_arbiter
    import regfile_pkg::*;
#(
    parameter int XLEN     = DEF_XLEN,
    parameter int NREGS    = DEF_NREGS,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1
)(
    input  logic                                  i_en,
    input  logic [NWR-1:0]                        i_we,
    input  logic [NWR-1:0][$clog2(NREGS)-1:0]     i_wr_addr,
    input  logic [NWR-1:0][XLEN-1:0]              i_wr_data,
    output logic [NREGS-1:0]                      o_reg_we,
    output logic [NREGS-1:0][XLEN-1:0]            o_reg_data,
    output logic                                  o_conflict
);
    localparam int AW = $clog2(NREGS);

    logic [NWR-1:0] w_valid;

    always_comb begin
        w_valid = '0;
        for (int p = 0; p < NWR; p++) begin
            w_valid[p] = i_en && i_we[p] && !((ZERO_REG != 0) && (i_wr_addr[p] == '0));
        end
    end

    // Later ports overwrite earlier ones, so the highest-index match wins.
    always_comb begin
        o_reg_we   = '0;
        o_reg_data = '0;
        for (int a = 0; a < NREGS; a++) begin
            for (int p = 0; p < NWR; p++) begin
                if (w_valid[p] && (i_wr_addr[p] == AW'(a))) begin
                    o_reg_we[a]   = 1'b1;
                    o_reg_data[a] = i_wr_data[p];
                end
            end
        end
    end

    always_comb begin
        o_conflict = 1'b0;
        for (int p = 0; p < NWR; p++) begin
            for (int q = p + 1; q < NWR; q++) begin
                if (w_valid[p] && w_valid[q] && (i_wr_addr[p] == i_wr_addr[q])) begin
                    o_conflict = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with boot-table init, bypass and zero register.
// Define REGFILE_MP_DEBUG_PORT_EN to expose the array copy and a committed-write counter.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN     = DEF_XLEN,
    parameter int NREGS    = DEF_NREGS,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1
)(
    input  logic          i_clk,
    input  logic          i_rstn,
    regfile_mp_if.slave   bus
);
    localparam int AW = $clog2(NREGS);

    rf_state_e                   r_state;
    rf_state_e                   w_nextState;
    logic [AW-1:0]               r_ptr;
    logic [AW-1:0]               w_nextPtr;
    logic                        r_ready;
    logic                        w_nextReady;
    logic                        r_conflict;
    logic                        w_nextConflict;
    logic [XLEN-1:0]             r_regs [NREGS];

    logic                        w_run;
    logic                        w_wrEn;
    logic                        w_conflict;
    logic [NREGS-1:0]            w_regWe;
    logic [NREGS-1:0][XLEN-1:0]  w_regData;

    assign w_run  = (r_state == RUN);
    // A reinit pulse suppresses every write, bypass and conflict in its cycle.
    assign w_wrEn = w_run && !bus.i_reinit;

    rf_wr_arbiter #(
        .XLEN     (XLEN),
        .NREGS    (NREGS),
        .NWR      (NWR),
        .ZERO_REG (ZERO_REG)
    ) u_arb (
        .i_en       (w_wrEn),
        .i_we       (bus.i_we),
        .i_wr_addr  (bus.i_wr_addr),
        .i_wr_data  (bus.i_wr_data),
        .o_reg_we   (w_regWe),
        .o_reg_data (w_regData),
        .o_conflict (w_conflict)
    );

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state    <= INIT;
            r_ptr      <= '0;
            r_ready    <= 1'b0;
            r_conflict <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_ptr      <= w_nextPtr;
            r_ready    <= w_nextReady;
            r_conflict <= w_nextConflict;
        end
    end

    always_comb begin
        w_nextState    = r_state;
        w_nextPtr      = r_ptr;
        w_nextReady    = r_ready;
        w_nextConflict = 1'b0;
        case (r_state)
            INIT: begin
                w_nextPtr = r_ptr + 1'b1;
                if (r_ptr == AW'(NREGS - 1)) begin
                    w_nextState = RUN;
                    w_nextReady = 1'b1;
                end
            end
            RUN: begin
                if (bus.i_reinit) begin
                    w_nextState = INIT;
                    w_nextPtr   = '0;
                    w_nextReady = 1'b0;
                end else begin
                    w_nextConflict = w_conflict;
                end
            end
            default: begin
                w_nextState = INIT;
                w_nextPtr   = '0;
                w_nextReady = 1'b0;
            end
        endcase
    end

    // The array has no reset; the boot sequence rewrites every entry instead.
    always_ff @(posedge i_clk) begin
        if (r_state == INIT) begin
            r_regs[r_ptr] <= XLEN'(rf_boot_word(32'(r_ptr)));
        end else begin
            for (int a = 0; a < NREGS; a++) begin
                if (w_regWe[a]) begin
                    r_regs[a] <= w_regData[a];
                end
            end
        end
    end

    always_comb begin
        bus.o_rd_data = '0;
        for (int r = 0; r < NRD; r++) begin
            if (w_run && !((ZERO_REG != 0) && (bus.i_rd_addr[r] == '0))) begin
                bus.o_rd_data[r] = w_regWe[bus.i_rd_addr[r]] ? w_regData[bus.i_rd_addr[r]]
                                                             : r_regs[bus.i_rd_addr[r]];
            end
        end
    end

    assign bus.o_ready       = r_ready;
    assign bus.o_wr_conflict = r_conflict;

`ifdef REGFILE_MP_DEBUG_PORT_EN
    logic [31:0] r_wrCount;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_wrCount <= '0;
        end else if (w_run && bus.i_reinit) begin
            r_wrCount <= '0;
        end else begin
            r_wrCount <= r_wrCount + 32'($countones(w_regWe));
        end
    end

    always_comb begin
        bus.o_dbg_regs = '0;
        for (int a = 0; a < NREGS; a++) begin
            if (!((ZERO_REG != 0) && (a == 0))) begin
                bus.o_dbg_regs[a] = r_regs[a];
            end
        end
    end

    assign bus.o_dbg_wr_count = r_wrCount;
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (default parameters).
// Debug-port checks are compiled in when REGFILE_MP_DEBUG_PORT_EN is defined.
module tb_regfile_mp;
    import regfile_pkg::*;

    logic clk = 1'b0;
    logic rstn;
    int   errors = 0;
    int   checks = 0;

    regfile_mp_if #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2)) bus ();

    regfile_mp #(
        .XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .ZERO_REG(1)
    ) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] we,
                                 input logic [4:0] wa0, input logic [31:0] wd0,
                                 input logic [4:0] wa1, input logic [31:0] wd1,
                                 input logic [4:0] ra0, input logic [4:0] ra1,
                                 input logic reinit);
        bus.i_we         = we;
        bus.i_wr_addr[0] = wa0;
        bus.i_wr_data[0] = wd0;
        bus.i_wr_addr[1] = wa1;
        bus.i_wr_data[1] = wd1;
        bus.i_rd_addr[0] = ra0;
        bus.i_rd_addr[1] = ra1;
        bus.i_reinit     = reinit;
        #1;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic readPair(input logic [4:0] ra0, input logic [4:0] ra1,
                            input logic [31:0] exp0, input logic [31:0] exp1, input string tag);
        applyStimulus(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, ra0, ra1, 1'b0);
        checkOutput({tag, "_rd0"}, 64'(bus.o_rd_data[0]), 64'(exp0));
        checkOutput({tag, "_rd1"}, 64'(bus.o_rd_data[1]), 64'(exp1));
    endtask

    // Runs a full init window and checks ready stays low for 31 edges and rises on the 32nd.
    task automatic runInit(input string tag);
        for (int c = 1; c <= 32; c++) begin
            stepCycle();
            if (c == 10) checkOutput({tag, "_rd_zero_in_init"}, 64'(bus.o_rd_data[0]), 64'd0);
            if (c == 31) checkOutput({tag, "_ready_c31"}, 64'(bus.o_ready), 64'd0);
            if (c == 32) checkOutput({tag, "_ready_c32"}, 64'(bus.o_ready), 64'd1);
        end
    endtask

    initial begin
        $display("[TB] regfile_mp directed test start");
        rstn = 1'b1;
        applyStimulus(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd1, 5'd5, 1'b0);
        rstn = 1'b0;
        #2;
        checkOutput("reset_ready", 64'(bus.o_ready), 64'd0);
        checkOutput("reset_conflict", 64'(bus.o_wr_conflict), 64'd0);
        checkOutput("reset_rd0", 64'(bus.o_rd_data[0]), 64'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Boot window with a write attempt at cycle 2 that must be ignored.
        for (int c = 1; c <= 32; c++) begin
            stepCycle();
            if (c == 1) applyStimulus(2'b01, 5'd3, 32'h55, 5'd0, 32'd0, 5'd3, 5'd1, 1'b0);
            if (c == 2) applyStimulus(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd3, 5'd1, 1'b0);
            if (c == 1) checkOutput("init_ready_c1", 64'(bus.o_ready), 64'd0);
            if (c == 2) checkOutput("init_rd_zero_c2", 64'(bus.o_rd_data[0]), 64'd0);
            if (c == 31) begin
                checkOutput("init_ready_c31", 64'(bus.o_ready), 64'd0);
                checkOutput("init_rd_zero_c31", 64'(bus.o_rd_data[1]), 64'd0);
                checkOutput("init_conflict_c31", 64'(bus.o_wr_conflict), 64'd0);
            end
            if (c == 32) checkOutput("init_ready_c32", 64'(bus.o_ready), 64'd1);
        end
        readPair(5'd1, 5'd5, 32'd24, 32'd5, "boot_1_5");
        readPair(5'd10, 5'd31, 32'd56, 32'd3, "boot_10_31");
        readPair(5'd7, 5'd3, 32'd0, 32'd0, "boot_7_3");

        // Bypass on a fresh write, then the array value one cycle later.
        applyStimulus(2'b01, 5'd8, 32'hDEADBEEF, 5'd0, 32'd0, 5'd8, 5'd2, 1'b0);
        checkOutput("bypass_same_cycle", 64'(bus.o_rd_data[0]), 64'hDEADBEEF);
        checkOutput("bypass_other_addr", 64'(bus.o_rd_data[1]), 64'd2);
        stepCycle();
        readPair(5'd8, 5'd2, 32'hDEADBEEF, 32'd2, "array_8");

        // Same-address conflict: port 1 wins, flag is a one-cycle pulse.
        applyStimulus(2'b11, 5'd12, 32'h11, 5'd12, 32'h22, 5'd12, 5'd12, 1'b0);
        checkOutput("conflict_bypass", 64'(bus.o_rd_data[0]), 64'h22);
        stepCycle();
        checkOutput("conflict_flag_set", 64'(bus.o_wr_conflict), 64'd1);
        readPair(5'd12, 5'd0, 32'h22, 32'd0, "conflict_winner");
        stepCycle();
        checkOutput("conflict_flag_clear", 64'(bus.o_wr_conflict), 64'd0);

        // Zero-register writes are dropped and never flag a conflict.
        applyStimulus(2'b11, 5'd0, 32'h33, 5'd0, 32'h44, 5'd0, 5'd0, 1'b0);
        checkOutput("zero_bypass", 64'(bus.o_rd_data[0]), 64'd0);
        stepCycle();
        checkOutput("zero_conflict", 64'(bus.o_wr_conflict), 64'd0);
        readPair(5'd0, 5'd12, 32'd0, 32'h22, "zero_read");

        // Two independent writes in one cycle.
        applyStimulus(2'b11, 5'd20, 32'hA, 5'd21, 32'hB, 5'd20, 5'd21, 1'b0);
        stepCycle();
        checkOutput("dual_conflict", 64'(bus.o_wr_conflict), 64'd0);
        readPair(5'd20, 5'd21, 32'hA, 32'hB, "dual_write");
`ifdef REGFILE_MP_DEBUG_PORT_EN
        checkOutput("dbg_count_before_reinit", 64'(bus.o_dbg_wr_count), 64'd4);
`endif

        // Reinit overrides a simultaneous write and reloads the boot table.
        applyStimulus(2'b01, 5'd1, 32'h99, 5'd0, 32'd0, 5'd1, 5'd8, 1'b0);
        bus.i_reinit = 1'b1;
        stepCycle();
        applyStimulus(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd1, 5'd8, 1'b0);
        checkOutput("reinit_ready_low", 64'(bus.o_ready), 64'd0);
        checkOutput("reinit_rd_zero", 64'(bus.o_rd_data[0]), 64'd0);
`ifdef REGFILE_MP_DEBUG_PORT_EN
        checkOutput("dbg_count_after_reinit", 64'(bus.o_dbg_wr_count), 64'd0);
`endif
        runInit("reinit");
        readPair(5'd1, 5'd8, 32'd24, 32'd0, "reinit_reload");

        // Asynchronous reset in the middle of init restarts the whole sequence.
        applyStimulus(2'b01, 5'd20, 32'h77, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0);
        stepCycle();
        rstn = 1'b0;
        #2;
        rstn = 1'b1;
        applyStimulus(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd20, 5'd10, 1'b0);
        for (int c = 1; c <= 10; c++) stepCycle();
        rstn = 1'b0;
        #2;
        checkOutput("midinit_reset_ready", 64'(bus.o_ready), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        runInit("midinit");
        readPair(5'd20, 5'd10, 32'd0, 32'd56, "midinit_reload");

        // Five committed writes among a zero-register drop and a conflict loser.
        applyStimulus(2'b11, 5'd4, 32'h104, 5'd5, 32'h105, 5'd0, 5'd0, 1'b0);
        stepCycle();
        applyStimulus(2'b11, 5'd6, 32'h106, 5'd0, 32'h999, 5'd0, 5'd0, 1'b0);
        stepCycle();
        applyStimulus(2'b11, 5'd7, 32'h1, 5'd7, 32'h107, 5'd0, 5'd0, 1'b0);
        stepCycle();
        applyStimulus(2'b10, 5'd0, 32'd0, 5'd8, 32'h108, 5'd0, 5'd0, 1'b0);
        stepCycle();
        readPair(5'd4, 5'd5, 32'h104, 32'h105, "final_4_5");
        readPair(5'd6, 5'd7, 32'h106, 32'h107, "final_6_7");
        readPair(5'd8, 5'd0, 32'h108, 32'd0, "final_8_0");
`ifdef REGFILE_MP_DEBUG_PORT_EN
        checkOutput("dbg_count_five", 64'(bus.o_dbg_wr_count), 64'd5);
        checkOutput("dbg_reg0", 64'(bus.o_dbg_regs[0]), 64'd0);
        checkOutput("dbg_reg1", 64'(bus.o_dbg_regs[1]), 64'd24);
        checkOutput("dbg_reg4", 64'(bus.o_dbg_regs[4]), 64'h104);
        checkOutput("dbg_reg7", 64'(bus.o_dbg_regs[7]), 64'h107);
        checkOutput("dbg_reg8", 64'(bus.o_dbg_regs[8]), 64'h108);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
